id_ex_pipe: RTL and testbench

- Pipeline register stage between the combinational decoder and the execute unit.
- Captures the decoded packet: operands, instruction, addresses, write controls, CSR data, compare flags and store data.
- Presents the packet to execute with a valid/ready handshake.
- Supports stall (hold), flush on taken jump, and an optional 2-entry skid buffer so the upstream ready is registered.

---
 rtl/tinyriscv_pkg.sv | 43 ++++
 rtl/id_ex_pipe_skid_buf.sv | 74 +++++++
 rtl/id_ex_pipe.sv | 99 +++++++++
 tb/tb_id_ex_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyriscv_pkg.sv
// Shared types and constants for the tinyriscv core: bus widths, write-enable
// encoding and the decode-to-execute pipeline packet.
package tinyriscv_pkg;

  localparam int InstBusW     = 32;
  localparam int InstAddrBusW = 32;
  localparam int MemAddrBusW  = 32;
  localparam int RegBusW      = 32;
  localparam int RegAddrBusW  = 5;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [InstBusW-1:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [InstBusW-1:0]     inst;
    logic [InstAddrBusW-1:0] inst_addr;
    logic [MemAddrBusW-1:0]  op1;
    logic [MemAddrBusW-1:0]  op2;
    logic                    reg_we;
    logic [RegAddrBusW-1:0]  reg_waddr;
    logic                    csr_we;
    logic [RegBusW-1:0]      csr_rdata;
    logic [MemAddrBusW-1:0]  csr_waddr;
    logic [2:0]              compare;
    logic [RegBusW-1:0]      store_data;
  } id_ex_pkt_t;

  localparam id_ex_pkt_t ID_EX_RESET_PKT = '{inst: INST_NOP, default: '0};

  // An empty slot must never write architectural state; the instruction
  // field optionally becomes a NOP so execute sees a clean bubble.
  function automatic id_ex_pkt_t make_bubble(input id_ex_pkt_t pkt, input logic to_nop);
    id_ex_pkt_t b;
    b        = pkt;
    b.reg_we = ~WriteEnable;
    b.csr_we = ~WriteEnable;
    if (to_nop) b.inst = INST_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_pipe_skid_buf.sv
// Generic valid/ready pipeline register (module pipe_skid_buf) with an optional
// second skid entry selected by SKID; hold freezes it, flush empties it.
module pipe_skid_buf #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SKID      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic up;
  logic down;

  assign up   = in_valid & in_ready & ~hold & ~flush;
  assign down = out_valid & out_ready & ~hold;

  generate
    if (SKID) begin : g_skid
      logic [WIDTH-1:0] skid_data;
      logic             skid_empty;

      // Upstream ready is the registered "skid empty" flag, so decode never
      // sees a combinational path from execute's ready.
      assign in_ready = skid_empty;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid  <= 1'b0;
          out_data   <= RESET_VAL;
          skid_data  <= RESET_VAL;
          skid_empty <= 1'b1;
        end else if (flush) begin
          out_valid  <= 1'b0;
          skid_empty <= 1'b1;
        end else if (down && !skid_empty) begin
          out_data   <= skid_data;
          skid_empty <= 1'b1;
        end else if (down || !out_valid) begin
          if (up) out_data <= in_data;
          out_valid <= up;
        end else if (up) begin
          skid_data  <= in_data;
          skid_empty <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_data  <= RESET_VAL;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (up) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else if (down) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline stage with hold, jump flush and bubble insertion.
// Define ID_EX_SKID_EN to add a skid entry and register the upstream ready.
module id_ex_pipe
  import tinyriscv_pkg::*;
#(
  parameter bit FLUSH_TO_NOP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic [InstBusW-1:0]     inst_i,
  input  logic [InstAddrBusW-1:0] inst_addr_i,
  input  logic [MemAddrBusW-1:0]  op1_i,
  input  logic [MemAddrBusW-1:0]  op2_i,
  input  logic                    reg_we_i,
  input  logic [RegAddrBusW-1:0]  reg_waddr_i,
  input  logic                    csr_we_i,
  input  logic [RegBusW-1:0]      csr_rdata_i,
  input  logic [MemAddrBusW-1:0]  csr_waddr_i,
  input  logic [2:0]              compare_i,
  input  logic [RegBusW-1:0]      store_data_i,
  input  logic                    hold_i,
  input  logic                    flush_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [InstBusW-1:0]     inst_o,
  output logic [InstAddrBusW-1:0] inst_addr_o,
  output logic [MemAddrBusW-1:0]  op1_o,
  output logic [MemAddrBusW-1:0]  op2_o,
  output logic                    reg_we_o,
  output logic [RegAddrBusW-1:0]  reg_waddr_o,
  output logic                    csr_we_o,
  output logic [RegBusW-1:0]      csr_rdata_o,
  output logic [MemAddrBusW-1:0]  csr_waddr_o,
  output logic [2:0]              compare_o,
  output logic [RegBusW-1:0]      store_data_o
);

`ifdef ID_EX_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  localparam int PKT_W = $bits(id_ex_pkt_t);

  id_ex_pkt_t in_pkt;
  id_ex_pkt_t q_pkt;
  id_ex_pkt_t out_pkt;

  assign in_pkt = '{
    inst:       inst_i,
    inst_addr:  inst_addr_i,
    op1:        op1_i,
    op2:        op2_i,
    reg_we:     reg_we_i,
    reg_waddr:  reg_waddr_i,
    csr_we:     csr_we_i,
    csr_rdata:  csr_rdata_i,
    csr_waddr:  csr_waddr_i,
    compare:    compare_i,
    store_data: store_data_i
  };

  pipe_skid_buf #(
    .WIDTH     (PKT_W),
    .RESET_VAL (ID_EX_RESET_PKT),
    .SKID      (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold_i),
    .flush     (flush_i),
    .in_valid  (id_valid_i),
    .in_ready  (id_ready_o),
    .in_data   (in_pkt),
    .out_valid (ex_valid_o),
    .out_ready (ex_ready_i),
    .out_data  (q_pkt)
  );

  // The stored payload is left untouched when the slot empties; only the
  // presented copy is turned into a bubble, so write enables can never leak.
  assign out_pkt = ex_valid_o ? q_pkt : make_bubble(q_pkt, FLUSH_TO_NOP);

  assign inst_o       = out_pkt.inst;
  assign inst_addr_o  = out_pkt.inst_addr;
  assign op1_o        = out_pkt.op1;
  assign op2_o        = out_pkt.op2;
  assign reg_we_o     = out_pkt.reg_we;
  assign reg_waddr_o  = out_pkt.reg_waddr;
  assign csr_we_o     = out_pkt.csr_we;
  assign csr_rdata_o  = out_pkt.csr_rdata;
  assign csr_waddr_o  = out_pkt.csr_waddr;
  assign compare_o    = out_pkt.compare;
  assign store_data_o = out_pkt.store_data;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the stage is modelled as a FIFO of depth 1
// (depth 2 when ID_EX_SKID_EN is defined) of accepted packets.
module tb_id_ex_pipe;
  import tinyriscv_pkg::*;

`ifdef ID_EX_SKID_EN
  localparam bit SKID_MODE = 1'b1;
`else
  localparam bit SKID_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  id_ex_pkt_t  drv = '0;
  id_ex_pkt_t  act;

  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, csr_rdata_o, csr_waddr_o, store_data_o;
  logic [4:0]  reg_waddr_o;
  logic [2:0]  compare_o;
  logic        reg_we_o, csr_we_o;

  id_ex_pkt_t  exp_q[$];
  int          occ = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        mon_rdy;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid_i   (id_valid),
    .id_ready_o   (id_ready),
    .inst_i       (drv.inst),
    .inst_addr_i  (drv.inst_addr),
    .op1_i        (drv.op1),
    .op2_i        (drv.op2),
    .reg_we_i     (drv.reg_we),
    .reg_waddr_i  (drv.reg_waddr),
    .csr_we_i     (drv.csr_we),
    .csr_rdata_i  (drv.csr_rdata),
    .csr_waddr_i  (drv.csr_waddr),
    .compare_i    (drv.compare),
    .store_data_i (drv.store_data),
    .hold_i       (hold),
    .flush_i      (flush),
    .ex_valid_o   (ex_valid),
    .ex_ready_i   (ex_ready),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .op1_o        (op1_o),
    .op2_o        (op2_o),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o),
    .csr_we_o     (csr_we_o),
    .csr_rdata_o  (csr_rdata_o),
    .csr_waddr_o  (csr_waddr_o),
    .compare_o    (compare_o),
    .store_data_o (store_data_o)
  );

  always_comb begin
    act            = '0;
    act.inst       = inst_o;
    act.inst_addr  = inst_addr_o;
    act.op1        = op1_o;
    act.op2        = op2_o;
    act.reg_we     = reg_we_o;
    act.reg_waddr  = reg_waddr_o;
    act.csr_we     = csr_we_o;
    act.csr_rdata  = csr_rdata_o;
    act.csr_waddr  = csr_waddr_o;
    act.compare    = compare_o;
    act.store_data = store_data_o;
  end

  task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // One clock of stimulus starting just after a rising edge; the model then
  // decides from the occupancy rules whether decode's packet was taken.
  task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic rdy,
                               input logic hld, input logic fl);
    id_ex_pkt_t p;
    logic       m_rdy, up, down;
    p.inst       = $urandom;
    p.inst_addr  = addr;
    p.op1        = $urandom;
    p.op2        = $urandom;
    p.reg_we     = 1'($urandom);
    p.reg_waddr  = 5'($urandom);
    p.csr_we     = 1'($urandom);
    p.csr_rdata  = $urandom;
    p.csr_waddr  = $urandom;
    p.compare    = 3'($urandom);
    p.store_data = $urandom;
    drv      = p;
    id_valid = v;
    ex_ready = rdy;
    hold     = hld;
    flush    = fl;
    @(posedge clk);
    m_rdy = SKID_MODE ? (occ < 2) : (occ == 0 || rdy);
    up    = v & m_rdy & ~hld & ~fl;
    down  = (occ > 0) & rdy & ~hld;
    if (fl) begin
      occ = 0;
      exp_q.delete();
    end else begin
      occ = occ - int'(down) + int'(up);
      if (up) exp_q.push_back(p);
    end
    #1;
  endtask

  task automatic doReset();
    mon_en   = 1'b0;
    id_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    checkOutput("rst_ex_valid", 256'(ex_valid), 256'(0));
    checkOutput("rst_id_ready", 256'(id_ready), 256'(1));
    checkOutput("rst_inst", 256'(inst_o), 256'(INST_NOP));
    checkOutput("rst_reg_we", 256'(reg_we_o), 256'(0));
    checkOutput("rst_csr_we", 256'(csr_we_o), 256'(0));
    checkOutput("rst_inst_addr", 256'(inst_addr_o), 256'(0));
    exp_q.delete();
    occ = 0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: every cycle compare handshake signals with the model and the
  // presented packet with the oldest expected one; retire it when execute takes it.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_rdy = SKID_MODE ? (occ < 2) : (occ == 0 || ex_ready);
      checkOutput("ex_valid", 256'(ex_valid), 256'(occ > 0));
      checkOutput("id_ready", 256'(id_ready), 256'(mon_rdy));
      if (occ > 0) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_depth", 256'(exp_q.size()), 256'(occ));
        end else begin
          checkOutput("payload", 256'(act), 256'(exp_q[0]));
          if (ex_ready && !hold && !flush) void'(exp_q.pop_front());
        end
      end else begin
        checkOutput("bubble", 256'({inst_o, reg_we_o, csr_we_o}), 256'({INST_NOP, 2'b00}));
      end
    end
  end

  initial begin
    logic [31:0] addr;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] stream of four packets");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] hold");
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 32'h204, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] hold with flush");
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 1'b1, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    doReset();
    repeat (2) applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    addr = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, addr, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      addr = addr + 32'd4;
    end

    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain", 256'(exp_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
